decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction decode stage between fetch and execute. Accepts one 32-bit instruction plus PC per handshake and classifies it for RV32I or RV64I (optionally with M). It produces a sign-extended immediate of the selected format, memory access size codes, register-write and control-flow flags, and an illegal-instruction flag. A two-entry skid buffer provides full-throughput valid/ready flow control and a same-cycle flush.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- ENABLE_M, 0: 1 accepts M-extension encodings (func7 = 0000001 on OP, and on OP-32 when XLEN=64).
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all buffered instructions.
- in_valid  in  1  instruction/PC presented.
- in_ready  out  1  stage can accept.
- in_instruction  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  passthrough PC.
- out_register1 / out_register2 / out_registerd  out  5 each  instruction [19:15] / [24:20] / [11:7].
- out_op_code  out  7  instruction [6:0].
- out_func3  out  3  instruction [14:12].
- out_func7  out  7  instruction [31:25].
- out_immediate  out  XLEN  sign-extended immediate.
- out_mem_read  out  3  load size code.
- out_mem_write  out  3  store size code.
- out_mem_unsigned  out  1  LBU/LHU/LWU.
- out_reg_write  out  1  writes registerd.
- out_branch / out_jump  out  1 each  conditional branch / JAL or JALR.
- out_illegal  out  1  encoding not legal for the configuration.

## Operation
- Immediate format by opcode:
  - I format: LOAD 0000011, OP-IMM 0010011, JALR 1100111, OP-IMM-32 0011011.
  - S format: 0100011.
  - B format: 1100011, bit 0 = 0.
  - U format: LUI 0110111 and AUIPC 0010111, [31:12] followed by 12 zero bits, then sign-extended to XLEN.
  - J format: 1101111, bit 0 = 0.
  - All other opcodes: 0.
- Size code: 000 none, 001 byte, 010 half, 011 word, 100 double.
  - Loads: func3 000/100 → 001, 001/101 → 010, 010 → 011, 110 → 011 (XLEN=64 only), 011 → 100 (XLEN=64 only).
  - Stores: func3 000/001/010 → 001/010/011, 011 → 100 (XLEN=64 only).
- out_mem_unsigned = load with func3[2]=1.
- out_reg_write = 1 for LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD, OP-32 and OP-IMM-32, AND registerd≠0 AND not illegal.
- Illegal conditions:
  - opcode not in the supported set; OP-32 and OP-IMM-32 are supported only when XLEN=64;
  - load or store func3 not listed above;
  - branch func3 010 or 011;
  - JALR func3 ≠ 000;
  - OP func7 not 0000000; 0100000 is legal only for func3 000/101, and 0000001 is legal only when ENABLE_M=1;
  - SLLI, SRLI or SRAI with a bad func7 (RV64: check [31:26]);
  - SYSTEM other than 0x00000073 or 0x00100073;
  - words 0x00000000 and 0xFFFFFFFF.
- FENCE 0001111 is legal and raises no flags.
- When out_illegal=1, out_mem_read, out_mem_write, out_branch and out_jump are forced to 0.

## Timing
- Reset: out_valid=0, in_ready=1, every out_* data field = 0, skid buffer empty.
- Latency: exactly 1 cycle from an in_valid&in_ready edge to out_valid.
- in_ready = skid entry empty (registered state, no combinational path from out_ready).
- Input handshake fires while the output is stalled (out_valid&!out_ready): the new entry goes to the skid register. When the output drains, the skid entry moves to the output, and a simultaneous new input is not possible because in_ready=0.
- Output handshake and input handshake in the same cycle: the output register loads the new entry, giving throughput of 1 per cycle.
- Output fields hold stable while out_valid&!out_ready.
- flush: at the next edge both entries are invalidated, out_valid=0 and in_ready=1. An input handshake in the flush cycle is dropped. flush wins over all other events.
- Reset asserted mid-stream: same as flush, and data fields are cleared.

## Structure
- Package decoder_pkg holds the opcode constants, size-code constants (SIZE_NONE … SIZE_DOUBLE), and a decoded_t struct bundling all out_* data fields.
- The combinational sub-module decode_comb (instruction → decoded_t, parametrised by XLEN and ENABLE_M) sits ahead of the registers. decode_stage itself holds only the skid buffer and output register of decoded_t plus PC.

## Test plan
- XLEN=32: 0xFE010113 (addi sp,sp,-32) → immediate 0xFFFFFFE0, reg_write=1, registerd=2, illegal=0, after 1 cycle.
- 0x00812E23 (sw s0,28(sp)) → immediate 0x0000001C, mem_write=011, reg_write=0. Under XLEN=32, 0x00813023 (sd) → illegal=1, mem_write=000. Under XLEN=64 the same word gives mem_write=100.
- 0xFE0008E3 (beq x0,x0,-16) → immediate 0xFFFFFFF0, branch=1. 0x02B50533 (mul) → illegal=1 with ENABLE_M=0 and 0 with ENABLE_M=1.
- Hold out_ready=0 and send 3 back-to-back instructions → the first two are accepted, then in_ready=0. Release out_ready → they are output in order, one per cycle, with no loss or duplication.
- Assert flush with both entries full and in_valid=1 → the next cycle has out_valid=0 and in_ready=1, and the dropped input never appears.
- Reset asserted mid-stream → all outputs 0 and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - opcode, size-code and decoded-entry definitions for the decode stage
package decoder_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] SIZE_NONE   = 3'b000;
    localparam logic [2:0] SIZE_BYTE   = 3'b001;
    localparam logic [2:0] SIZE_HALF   = 3'b010;
    localparam logic [2:0] SIZE_WORD   = 3'b011;
    localparam logic [2:0] SIZE_DOUBLE = 3'b100;

    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;

    // Immediate is held at the widest supported XLEN; narrower stages use the low bits,
    // which are already correctly sign-extended.
    typedef struct packed {
        logic [4:0]  register1;
        logic [4:0]  register2;
        logic [4:0]  registerd;
        logic [6:0]  op_code;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [63:0] immediate;
        logic [2:0]  mem_read;
        logic [2:0]  mem_write;
        logic        mem_unsigned;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } decoded_t;

    // Register-register ALU func7 legality, shared by OP and OP-32.
    function automatic logic op_func7_bad(input logic [6:0] func7, input logic [2:0] func3,
                                          input logic m_enabled);
        logic bad;
        case (func7)
            7'b0000000: bad = 1'b0;
            7'b0100000: bad = !((func3 == 3'b000) || (func3 == 3'b101));
            7'b0000001: bad = !m_enabled;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational instruction word to decoded_t classifier
module decode_comb
    import decoder_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0
) (
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    localparam logic IS_RV64 = (XLEN == 64);
    localparam logic M_EN    = (ENABLE_M != 0);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];
    assign rd  = instr_i[11:7];

    assign imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
    assign imm_j = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    logic        supported;
    logic        bad;
    logic        illegal;
    logic        writes_rd;
    logic        is_branch;
    logic        is_jump;
    logic [2:0]  ld_size;
    logic [2:0]  st_size;
    logic [63:0] imm;

    // Per-opcode classification: immediate format, access size and encoding faults.
    always_comb begin
        supported = 1'b0;
        bad       = 1'b0;
        writes_rd = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        ld_size   = SIZE_NONE;
        st_size   = SIZE_NONE;
        imm       = '0;
        case (opc)
            OPC_LOAD: begin
                supported = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
                case (f3)
                    3'b000, 3'b100: ld_size = SIZE_BYTE;
                    3'b001, 3'b101: ld_size = SIZE_HALF;
                    3'b010:         ld_size = SIZE_WORD;
                    3'b110: begin
                        ld_size = IS_RV64 ? SIZE_WORD : SIZE_NONE;
                        bad     = !IS_RV64;
                    end
                    3'b011: begin
                        ld_size = IS_RV64 ? SIZE_DOUBLE : SIZE_NONE;
                        bad     = !IS_RV64;
                    end
                    default:        bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                supported = 1'b1;
                imm       = imm_s;
                case (f3)
                    3'b000: st_size = SIZE_BYTE;
                    3'b001: st_size = SIZE_HALF;
                    3'b010: st_size = SIZE_WORD;
                    3'b011: begin
                        st_size = IS_RV64 ? SIZE_DOUBLE : SIZE_NONE;
                        bad     = !IS_RV64;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                supported = 1'b1;
                is_branch = 1'b1;
                imm       = imm_b;
                bad       = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                supported = 1'b1;
                writes_rd = 1'b1;
                is_jump   = 1'b1;
                imm       = imm_j;
            end
            OPC_JALR: begin
                supported = 1'b1;
                writes_rd = 1'b1;
                is_jump   = 1'b1;
                imm       = imm_i;
                bad       = (f3 != 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                supported = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_u;
            end
            OPC_OP_IMM: begin
                supported = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
                // RV64 shifts use a 6-bit shamt, so only [31:26] carries the func code.
                if (f3 == 3'b001) begin
                    bad = IS_RV64 ? (instr_i[31:26] != 6'b000000) : (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    bad = IS_RV64 ? !((instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000))
                                  : !((f7 == 7'b0000000) || (f7 == 7'b0100000));
                end
            end
            OPC_OP_IMM_32: begin
                supported = IS_RV64;
                writes_rd = 1'b1;
                imm       = imm_i;
                if (f3 == 3'b001) begin
                    bad = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    bad = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
                end
            end
            OPC_OP: begin
                supported = 1'b1;
                writes_rd = 1'b1;
                bad       = op_func7_bad(f7, f3, M_EN);
            end
            OPC_OP_32: begin
                supported = IS_RV64;
                writes_rd = 1'b1;
                bad       = op_func7_bad(f7, f3, M_EN);
            end
            OPC_MISC_MEM: begin
                supported = 1'b1;
            end
            OPC_SYSTEM: begin
                supported = 1'b1;
                bad       = (instr_i != WORD_ECALL) && (instr_i != WORD_EBREAK);
            end
            default: begin
                supported = 1'b0;
            end
        endcase
    end

    assign illegal = !supported || bad || (instr_i == 32'h0000_0000) || (instr_i == 32'hFFFF_FFFF);

    // Assemble the entry; side-effect flags are suppressed for illegal encodings.
    always_comb begin
        dec_o              = '0;
        dec_o.register1    = instr_i[19:15];
        dec_o.register2    = instr_i[24:20];
        dec_o.registerd    = rd;
        dec_o.op_code      = opc;
        dec_o.func3        = f3;
        dec_o.func7        = f7;
        dec_o.immediate    = imm;
        dec_o.mem_read     = illegal ? SIZE_NONE : ld_size;
        dec_o.mem_write    = illegal ? SIZE_NONE : st_size;
        dec_o.mem_unsigned = (opc == OPC_LOAD) && f3[2];
        dec_o.reg_write    = writes_rd && (rd != 5'd0) && !illegal;
        dec_o.branch       = is_branch && !illegal;
        dec_o.jump         = is_jump && !illegal;
        dec_o.illegal      = illegal;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with two-entry skid buffer and flush
module decode_stage
    import decoder_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instruction,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_register1,
    output logic [4:0]      out_register2,
    output logic [4:0]      out_registerd,
    output logic [6:0]      out_op_code,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [XLEN-1:0] out_immediate,
    output logic [2:0]      out_mem_read,
    output logic [2:0]      out_mem_write,
    output logic            out_mem_unsigned,
    output logic            out_reg_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    decoded_t dec_w;

    decode_comb #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode_comb (
        .instr_i (in_instruction),
        .dec_o   (dec_w)
    );

    decoded_t        out_q, out_d;
    decoded_t        skid_q, skid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_fire;

    // Ready depends only on registered skid occupancy, never on out_ready.
    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;

    // Next-state: flush dominates; a free output slot takes the skid entry first, else the input.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_d       = dec_w;
                out_pc_d    = in_pc;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = dec_w;
            skid_pc_d    = in_pc;
        end
    end

    // State registers; reset also clears every data field.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // Upper immediate bits are meaningless when XLEN is narrower than the stored width.
    logic unused_imm;
    assign unused_imm = ^out_q.immediate;

    assign out_valid        = out_valid_q;
    assign out_pc           = out_pc_q;
    assign out_register1    = out_q.register1;
    assign out_register2    = out_q.register2;
    assign out_registerd    = out_q.registerd;
    assign out_op_code      = out_q.op_code;
    assign out_func3        = out_q.func3;
    assign out_func7        = out_q.func7;
    assign out_immediate    = out_q.immediate[XLEN-1:0];
    assign out_mem_read     = out_q.mem_read;
    assign out_mem_write    = out_q.mem_write;
    assign out_mem_unsigned = out_q.mem_unsigned;
    assign out_reg_write    = out_q.reg_write;
    assign out_branch       = out_q.branch;
    assign out_jump         = out_q.jump;
    assign out_illegal      = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [63:0] pc;
    int          tests = 0;
    int          failed = 0;

    // a: XLEN=32 no M, b: XLEN=64 no M, c: XLEN=32 with M
    logic        a_in_ready, a_out_valid, a_mu, a_rw, a_br, a_jp, a_il;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [6:0]  a_opc, a_f7;
    logic [2:0]  a_f3, a_mr, a_mw;

    logic        b_in_ready, b_out_valid, b_mu, b_rw, b_br, b_jp, b_il;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [6:0]  b_opc, b_f7;
    logic [2:0]  b_f3, b_mr, b_mw;

    logic        c_in_ready, c_out_valid, c_mu, c_rw, c_br, c_jp, c_il;
    logic [31:0] c_pc, c_imm;
    logic [4:0]  c_rs1, c_rs2, c_rd;
    logic [6:0]  c_opc, c_f7;
    logic [2:0]  c_f3, c_mr, c_mw;

    decode_stage #(.XLEN(32), .ENABLE_M(0)) dut_a (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instruction(instr), .in_pc(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_register1(a_rs1), .out_register2(a_rs2), .out_registerd(a_rd),
        .out_op_code(a_opc), .out_func3(a_f3), .out_func7(a_f7), .out_immediate(a_imm),
        .out_mem_read(a_mr), .out_mem_write(a_mw), .out_mem_unsigned(a_mu), .out_reg_write(a_rw),
        .out_branch(a_br), .out_jump(a_jp), .out_illegal(a_il));

    decode_stage #(.XLEN(64), .ENABLE_M(0)) dut_b (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instruction(instr), .in_pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_register1(b_rs1), .out_register2(b_rs2), .out_registerd(b_rd),
        .out_op_code(b_opc), .out_func3(b_f3), .out_func7(b_f7), .out_immediate(b_imm),
        .out_mem_read(b_mr), .out_mem_write(b_mw), .out_mem_unsigned(b_mu), .out_reg_write(b_rw),
        .out_branch(b_br), .out_jump(b_jp), .out_illegal(b_il));

    decode_stage #(.XLEN(32), .ENABLE_M(1)) dut_c (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instruction(instr), .in_pc(pc[31:0]), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_pc(c_pc), .out_register1(c_rs1), .out_register2(c_rs2), .out_registerd(c_rd),
        .out_op_code(c_opc), .out_func3(c_f3), .out_func7(c_f7), .out_immediate(c_imm),
        .out_mem_read(c_mr), .out_mem_write(c_mw), .out_mem_unsigned(c_mu), .out_reg_write(c_rw),
        .out_branch(c_br), .out_jump(c_jp), .out_illegal(c_il));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [63:0] p);
        in_valid = 1'b1;
        instr    = w;
        pc       = p;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", a_out_valid, 0);
        check("rst_ready", a_in_ready, 1);
        check("rst_imm", a_imm, 0);
        check("rst_pc", a_pc, 0);
        check("rst_rd", a_rd, 0);
        check("rst_b_imm", b_imm, 0);
        reset = 1'b0;

        send(32'hFE010113, 64'h100);
        check("addi_pre_valid", a_out_valid, 0);
        tick();
        check("addi_valid", a_out_valid, 1);
        check("addi_imm", a_imm, 32'hFFFFFFE0);
        check("addi_rw", a_rw, 1);
        check("addi_rd", a_rd, 2);
        check("addi_il", a_il, 0);
        check("addi_pc", a_pc, 32'h100);
        check("addi_b_imm", b_imm, 64'hFFFFFFFFFFFFFFE0);

        send(32'h00812E23, 64'h104);
        tick();
        check("sw_valid", a_out_valid, 1);
        check("sw_imm", a_imm, 32'h1C);
        check("sw_mw", a_mw, 3'b011);
        check("sw_rw", a_rw, 0);

        send(32'h00813023, 64'h108);
        tick();
        check("sd32_il", a_il, 1);
        check("sd32_mw", a_mw, 3'b000);
        check("sd64_mw", b_mw, 3'b100);
        check("sd64_il", b_il, 0);

        send(32'hFE0008E3, 64'h10C);
        tick();
        check("beq_imm", a_imm, 32'hFFFFFFF0);
        check("beq_br", a_br, 1);
        check("beq_rw", a_rw, 0);

        send(32'h02B50533, 64'h110);
        tick();
        check("mul_noM_il", a_il, 1);
        check("mul_noM_rw", a_rw, 0);
        check("mul_M_il", c_il, 0);
        check("mul_M_rw", c_rw, 1);
        check("mul_M_rd", c_rd, 10);

        send(32'h0040C503, 64'h114);
        tick();
        check("lbu_mr", a_mr, 3'b001);
        check("lbu_mu", a_mu, 1);
        check("lbu_imm", a_imm, 4);

        send(32'h123452B7, 64'h118);
        tick();
        check("lui_imm", a_imm, 32'h12345000);
        check("lui_rd", a_rd, 5);
        check("lui_rw", a_rw, 1);
        check("lui_b_imm", b_imm, 64'h0000000012345000);

        send(32'h00000073, 64'h11C);
        tick();
        check("ecall_il", a_il, 0);
        check("ecall_rw", a_rw, 0);

        send(32'h00200073, 64'h120);
        tick();
        check("sys_bad_il", a_il, 1);

        send(32'hFFFFFFFF, 64'h124);
        tick();
        check("ones_il", a_il, 1);
        check("ones_b_il", b_il, 1);

        send(32'h4200D093, 64'h128);
        tick();
        check("srai32_il", a_il, 1);
        check("srai64_il", b_il, 0);

        send(32'h008000EF, 64'h12C);
        tick();
        check("jal_jp", a_jp, 1);
        check("jal_imm", a_imm, 8);
        check("jal_rw", a_rw, 1);

        in_valid = 1'b0;
        tick();
        check("idle_valid", a_out_valid, 0);

        // backpressure: three back-to-back with out_ready low
        out_ready = 1'b0;
        send(32'h00100093, 64'h200);
        tick();
        check("bp1_valid", a_out_valid, 1);
        check("bp1_ready", a_in_ready, 1);
        check("bp1_pc", a_pc, 32'h200);
        send(32'h00200093, 64'h204);
        tick();
        check("bp2_ready", a_in_ready, 0);
        check("bp2_pc_hold", a_pc, 32'h200);
        check("bp2_imm_hold", a_imm, 1);
        send(32'h00300093, 64'h208);
        tick();
        check("bp3_ready", a_in_ready, 0);
        check("bp3_pc_hold", a_pc, 32'h200);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drain1_valid", a_out_valid, 1);
        check("drain1_pc", a_pc, 32'h204);
        check("drain1_imm", a_imm, 2);
        check("drain1_ready", a_in_ready, 1);
        tick();
        check("drain2_valid", a_out_valid, 0);

        // flush with both entries full and a dropped input
        out_ready = 1'b0;
        send(32'h00400093, 64'h300);
        tick();
        send(32'h00500093, 64'h304);
        tick();
        check("fl_full_ready", a_in_ready, 0);
        flush = 1'b1;
        send(32'h00600093, 64'h308);
        tick();
        check("fl_valid", a_out_valid, 0);
        check("fl_ready", a_in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fl_after_valid", a_out_valid, 0);

        // flush with skid empty: input accepted-looking handshake is dropped
        out_ready = 1'b0;
        send(32'h00700093, 64'h310);
        tick();
        flush = 1'b1;
        send(32'h00800093, 64'h314);
        tick();
        check("fl2_valid", a_out_valid, 0);
        check("fl2_ready", a_in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fl2_after_valid", a_out_valid, 0);

        // reset mid-stream
        out_ready = 1'b0;
        send(32'hFE010113, 64'h400);
        tick();
        send(32'h00812E23, 64'h404);
        tick();
        reset = 1'b1;
        tick();
        check("mrst_valid", a_out_valid, 0);
        check("mrst_ready", a_in_ready, 1);
        check("mrst_imm", a_imm, 0);
        check("mrst_pc", a_pc, 0);
        check("mrst_rd", a_rd, 0);
        check("mrst_opc", a_opc, 0);
        check("mrst_rw", a_rw, 0);
        reset = 1'b0; out_ready = 1'b1;
        send(32'h00812E23, 64'h408);
        tick();
        check("post_rst_valid", a_out_valid, 1);
        check("post_rst_pc", a_pc, 32'h408);
        check("post_rst_mw", a_mw, 3'b011);
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
